// File: rtl/iot_pkg.sv
// Shared definitions for the IOT byte-stream transmit path.
// Contents: word/byte/round geometry, transmit FSM state type, function-select
// encodings understood by the receiver, and a saturating 16-bit increment.
package iot_pkg;

  localparam int IOT_WORD_W    = 128;
  localparam int IOT_BYTES     = 16;
  localparam int IOT_ROUND_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } tx_state_t;

  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;
  localparam logic [2:0] FN_EXT  = 3'd4;
  localparam logic [2:0] FN_EXC  = 3'd5;
  localparam logic [2:0] FN_PMAX = 3'd6;
  localparam logic [2:0] FN_PMIN = 3'd7;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/iot_word_fifo.sv
// Word FIFO between the upstream producer and the byte serializer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (pointers only)
//   push_i         write request; ignored when full
//   push_data_i    word to write
//   pop_i          read request; ignored when empty
//   pop_data_o     head word (valid while !empty_o)
//   full_o/empty_o occupancy flags derived from registered pointers
module iot_word_fifo #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/iot_byte_tx.sv
// Transmit side of the IOT byte-stream interface: buffers 128-bit words and
// serializes each into 16 bytes, MSB byte first, honouring the receiver busy.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_valid/wr_data     upstream word; accepted when wr_valid && wr_ready
//   wr_ready             FIFO not full
//   cfg_fn_sel           requested function, sampled at round start only
//   busy                 receiver busy; gates launch of the next byte
//   in_en/iot_in         registered byte strobe and byte (0 when idle)
//   fn_sel               registered function select, stable over a round
//   round_done           pulse when the word counter wraps
//   idle                 FSM idle and FIFO empty
//   tx_words             completed-word counter (only with IOT_BYTE_TX_STATS_EN)
// Build option: define IOT_BYTE_TX_STATS_EN to add the tx_words output.
module iot_byte_tx
  import iot_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WORD_W    = IOT_WORD_W,
  parameter int ROUND_LEN = IOT_ROUND_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [2:0]        cfg_fn_sel,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        iot_in,
  output logic [2:0]        fn_sel,
  output logic              round_done,
`ifdef IOT_BYTE_TX_STATS_EN
  output logic [15:0]       tx_words,
`endif
  output logic              idle
);

  localparam int WI_W = $clog2(ROUND_LEN);
  localparam int BI_W = $clog2(IOT_BYTES);

  tx_state_t         state_q;
  logic [WORD_W-1:0] shift_q;
  logic [BI_W-1:0]   byte_idx_q;
  logic [WI_W-1:0]   word_idx_q;
  logic              in_en_q, round_done_q;
  logic [7:0]        iot_in_q;
  logic [2:0]        fn_sel_q;

  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              pop, send_fire, word_done;

  iot_word_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_valid),
    .push_data_i(wr_data),
    .pop_i      (pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // A word is fetched only from IDLE or HOLD, and only when the receiver is free.
  assign pop       = ((state_q == IDLE) || (state_q == HOLD)) && !fifo_empty && !busy;
  assign send_fire = (state_q == SEND) && !busy;
  assign word_done = send_fire && (byte_idx_q == BI_W'(IOT_BYTES-1));

  assign wr_ready   = !fifo_full;
  assign idle       = (state_q == IDLE) && fifo_empty;
  assign in_en      = in_en_q;
  assign iot_in     = iot_in_q;
  assign fn_sel     = fn_sel_q;
  assign round_done = round_done_q;

  always_ff @(posedge clk) begin
    if (pop)            shift_q <= fifo_head;
    else if (send_fire) shift_q <= shift_q << 8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      in_en_q      <= 1'b0;
      iot_in_q     <= 8'h00;
      fn_sel_q     <= 3'd0;
      round_done_q <= 1'b0;
    end else begin
      // Pulses together with the wrap of word_idx, i.e. as the last byte of
      // the round's final word is launched.
      round_done_q <= word_done && (word_idx_q == WI_W'(ROUND_LEN-1));
      in_en_q      <= 1'b0;
      iot_in_q     <= 8'h00;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= SEND;
            if (word_idx_q == '0) fn_sel_q <= cfg_fn_sel;
          end
        end
        SEND: begin
          if (send_fire) begin
            in_en_q  <= 1'b1;
            iot_in_q <= shift_q[WORD_W-1 -: 8];
            if (word_done) begin
              byte_idx_q <= '0;
              word_idx_q <= word_idx_q + WI_W'(1);
              state_q    <= HOLD;
            end else begin
              byte_idx_q <= byte_idx_q + BI_W'(1);
            end
          end
        end
        HOLD: begin
          if (!busy) begin
            if (pop) begin
              state_q <= SEND;
              if (word_idx_q == '0) fn_sel_q <= cfg_fn_sel;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IOT_BYTE_TX_STATS_EN
  logic [15:0] tx_words_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tx_words_q <= 16'd0;
    else if (word_done) tx_words_q <= sat_inc16(tx_words_q);
  end
  assign tx_words = tx_words_q;
`endif

endmodule

// File: tb/tb_iot_byte_tx.sv
module tb_iot_byte_tx;
  import iot_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [127:0] W0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic [127:0] wr_data = '0;
  logic         wr_ready;
  logic [2:0]   cfg_fn_sel = 3'd0;
  logic         busy = 1'b0;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         round_done;
  logic         idle;
`ifdef IOT_BYTE_TX_STATS_EN
  logic [15:0]  tx_words;
`endif

  iot_byte_tx #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .cfg_fn_sel(cfg_fn_sel),
    .busy      (busy),
    .in_en     (in_en),
    .iot_in    (iot_in),
    .fn_sel    (fn_sel),
    .round_done(round_done),
`ifdef IOT_BYTE_TX_STATS_EN
    .tx_words  (tx_words),
`endif
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       en;
    logic [7:0] b;
  } vec_t;

  vec_t         tbl[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic [127:0] exp_words [16];
  logic [2:0]   exp_fn    [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic busy_at_release);
    wr_valid = 1'b0;
    busy     = busy_at_release;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic add_vec(input logic b_busy, input logic b_en, input logic [7:0] b_byte);
    vec_t v;
    v.busy = b_busy; v.en = b_en; v.b = b_byte;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      busy = tbl[i].busy;
      tick();
      chk($sformatf("%s[%0d].in_en", name, i), 128'(in_en), 128'(tbl[i].en));
      chk($sformatf("%s[%0d].iot_in", name, i), 128'(iot_in), 128'(tbl[i].b));
    end
    busy = 1'b0;
    tbl.delete();
  endtask

  task automatic push_one(input logic [127:0] w);
    chk("push.wr_ready", 128'(wr_ready), 128'(1'b1));
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  // Pushes exp_words[start..n-1] under flow control while collecting bytes of
  // words 0..n-1 and counting round_done pulses.
  task automatic stream(input int start, input int n, input int chg_after,
                        input logic [2:0] new_cfg, input int exp_rd_cnt, input int exp_rd_at);
    int           pi, pg, w, b, cyc, rd_cnt, rd_at;
    logic         p_acc;
    logic [127:0] acc_w;
    pi = start; pg = 0; w = 0; b = 0; cyc = 0; rd_cnt = 0; rd_at = -1; acc_w = '0;
    fork
      begin
        while (pi < n && pg < 2000) begin
          wr_valid = 1'b1;
          wr_data  = exp_words[pi];
          p_acc    = wr_ready;
          tick();
          if (p_acc) begin
            if (pi == chg_after) cfg_fn_sel = new_cfg;
            pi++;
          end
          pg++;
        end
        wr_valid = 1'b0;
      end
      begin
        while (w < n && cyc < 3000) begin
          tick();
          cyc++;
          if (in_en) begin
            acc_w = {acc_w[119:0], iot_in};
            b++;
            if (b == 16) begin
              chk($sformatf("stream.word%0d", w), acc_w, exp_words[w]);
              chk($sformatf("stream.fn_sel%0d", w), 128'(fn_sel), 128'(exp_fn[w]));
              w++;
              b = 0;
            end
          end
          if (round_done) begin rd_cnt++; rd_at = w; end
        end
        repeat (3) begin
          tick();
          if (round_done) begin rd_cnt++; rd_at = w; end
        end
        chk("stream.words_received", 128'(w), 128'(n));
        chk("stream.round_done_count", 128'(rd_cnt), 128'(exp_rd_cnt));
        if (exp_rd_cnt > 0) chk("stream.round_done_after_word", 128'(rd_at), 128'(exp_rd_at));
      end
    join
  endtask

  initial begin
    int   acc_cnt;
    logic saw_en, found;

    // Reset state
    do_reset(1'b0);
    chk("rst.in_en", 128'(in_en), 128'(1'b0));
    chk("rst.iot_in", 128'(iot_in), 128'(8'h00));
    chk("rst.fn_sel", 128'(fn_sel), 128'(3'd0));
    chk("rst.round_done", 128'(round_done), 128'(1'b0));
    chk("rst.wr_ready", 128'(wr_ready), 128'(1'b1));
    chk("rst.idle", 128'(idle), 128'(1'b1));
`ifdef IOT_BYTE_TX_STATS_EN
    chk("rst.tx_words", 128'(tx_words), 128'(16'd0));
`endif

    // 1: single word, receiver always ready
    push_one(W0);
    chk("t1.idle_after_push", 128'(idle), 128'(1'b0));
    tick();
    chk("t1.no_byte_yet", 128'(in_en), 128'(1'b0));
    for (int k = 0; k < 16; k++) add_vec(1'b0, 1'b1, 8'(8'h11 * k));
    add_vec(1'b0, 1'b0, 8'h00);
    run_table("t1");
    tick();
    chk("t1.idle_end", 128'(idle), 128'(1'b1));

    // 2: busy for 3 cycles after byte 5
    push_one(W0);
    tick();
    for (int k = 0; k < 6; k++) add_vec(1'b0, 1'b1, 8'(8'h11 * k));
    for (int k = 0; k < 3; k++) add_vec(1'b1, 1'b0, 8'h00);
    for (int k = 6; k < 16; k++) add_vec(1'b0, 1'b1, 8'(8'h11 * k));
    add_vec(1'b0, 1'b0, 8'h00);
    run_table("t2");

    // 3: one full round plus one word, cfg change mid-round
    for (int i = 0; i < 16; i++) begin
      exp_words[i] = {32'h1000_0000 + 32'(i), 32'h2000_00A0 + 32'(i),
                      32'h3000_0B00 + 32'(i), 32'h4000_C000 + 32'(i)};
      exp_fn[i]    = (i < 8) ? FN_AVG : FN_PMAX;
    end
    do_reset(1'b0);
    cfg_fn_sel = FN_AVG;
    stream(0, 9, 2, FN_PMAX, 1, 8);

    // 4: fill FIFO while receiver busy, then drain in order
    for (int i = 0; i < 16; i++) exp_fn[i] = FN_EXC;
    cfg_fn_sel = FN_EXC;
    do_reset(1'b1);
    acc_cnt = 0;
    saw_en  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wr_valid = 1'b1;
      wr_data  = exp_words[acc_cnt];
      found    = wr_ready;
      tick();
      if (found) acc_cnt++;
      if (in_en) saw_en = 1'b1;
    end
    wr_valid = 1'b0;
    chk("t4.accepted", 128'(acc_cnt), 128'(DEPTH));
    chk("t4.wr_ready_full", 128'(wr_ready), 128'(1'b0));
    chk("t4.no_byte_while_busy", 128'(saw_en), 128'(1'b0));
    chk("t4.idle_full", 128'(idle), 128'(1'b0));
    busy = 1'b0;
    stream(DEPTH, DEPTH + 2, -1, FN_EXC, 0, 0);

    // 5: reset in the middle of a word with a second word queued
    do_reset(1'b0);
    push_one(W0);
    push_one(128'hFFEEDDCC_BBAA9988_77665544_33221100);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (in_en && iot_in == 8'h99) found = 1'b1;
    end
    chk("t5.byte9_seen", 128'(found), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("t5.in_en_async", 128'(in_en), 128'(1'b0));
    chk("t5.iot_in_async", 128'(iot_in), 128'(8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5.idle", 128'(idle), 128'(1'b1));
    chk("t5.wr_ready", 128'(wr_ready), 128'(1'b1));
    saw_en = 1'b0;
    repeat (20) begin
      tick();
      if (in_en) saw_en = 1'b1;
    end
    chk("t5.fifo_discarded", 128'(saw_en), 128'(1'b0));

`ifdef IOT_BYTE_TX_STATS_EN
    // 6: completed-word counter
    for (int i = 0; i < 16; i++) exp_fn[i] = FN_MAX;
    cfg_fn_sel = FN_MAX;
    do_reset(1'b0);
    stream(0, 3, -1, FN_MAX, 0, 0);
    chk("t6.tx_words", 128'(tx_words), 128'(16'd3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
